// File: rtl/silife_pkg.sv
// ----------------------------------------------------------------------------
// silife_pkg
// Shared definitions for the SPI-target to Wishbone-initiator bridge:
// command opcodes, frame bit positions and the Wishbone FSM state type.
// ----------------------------------------------------------------------------
package silife_pkg;

   localparam logic [7:0] OP_WRITE   = 8'h02;
   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_CLR_ERR = 8'h05;

   // Frame bit counts at which each field is complete.
   localparam logic [6:0] BIT_OPCODE = 7'd8;
   localparam logic [6:0] BIT_ADDR   = 7'd32;
   localparam logic [6:0] BIT_DUMMY  = 7'd40;
   localparam logic [6:0] BIT_WDATA  = 7'd64;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_REQ  = 2'd1,
      WB_DONE = 2'd2
   } wb_state_t;

   function automatic logic op_is_known(input logic [7:0] op);
      return (op == OP_WRITE) || (op == OP_READ) || (op == OP_CLR_ERR);
   endfunction

endpackage

// File: rtl/silife_spi_target_shifter.sv
// ----------------------------------------------------------------------------
// silife_spi_target_shifter
// SPI mode-0 target front end. Synchronizes SCK/CS/MOSI into clk, detects
// SCK and CS edges, counts frame bits, assembles opcode/address/write data
// and shifts captured read data out on MISO.
//
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   spi_sck/cs/mosi      asynchronous SPI pins from the host
//   rd_data              read data to return on MISO (loaded after bit 39)
//   spi_miso, _oe        MISO data and output enable
//   stb_opcode/addr/wdata  one-clk pulses when bit 8 / 32 / 64 is reached
//   opcode, addr24, wdata  assembled frame fields, valid from their strobe on
// ----------------------------------------------------------------------------
module silife_spi_target_shifter
   import silife_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_sck,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   input  logic [31:0] rd_data,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        stb_opcode,
   output logic        stb_addr,
   output logic        stb_wdata,
   output logic [7:0]  opcode,
   output logic [23:0] addr24,
   output logic [31:0] wdata
);

   logic [2:0]  sck_sync_q, sck_sync_d;
   logic [2:0]  cs_sync_q, cs_sync_d;
   logic [1:0]  mosi_sync_q, mosi_sync_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [30:0] sh_q, sh_d;
   logic [7:0]  op_q, op_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] out_q, out_d;
   logic        stb_op_q, stb_op_d;
   logic        stb_addr_q, stb_addr_d;
   logic        stb_wdata_q, stb_wdata_d;

   logic sck_rise, sck_fall;
   logic cs_fall, cs_rise, cs_active;
   logic mosi_s;

   always_comb begin
      sck_sync_d  = {sck_sync_q[1:0], spi_sck};
      cs_sync_d   = {cs_sync_q[1:0], spi_cs};
      mosi_sync_d = {mosi_sync_q[0], spi_mosi};

      // Stage 1 is the synchronized sample, stage 2 the edge-detect history.
      sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
      sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
      cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
      cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
      cs_active = ~cs_sync_q[1];
      mosi_s    = mosi_sync_q[1];

      cnt_d       = cnt_q;
      sh_d        = sh_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      out_d       = out_q;
      stb_op_d    = 1'b0;
      stb_addr_d  = 1'b0;
      stb_wdata_d = 1'b0;

      if (cs_fall) begin
         cnt_d = '0;
         sh_d  = '0;
         op_d  = '0;
      end else if (cs_rise) begin
         // Abandons a partial frame; field strobes can no longer fire.
         cnt_d = '0;
      end else if (cs_active && sck_rise) begin
         sh_d = {sh_q[29:0], mosi_s};
         // Saturate so trailing bits after the frame are harmless.
         if (cnt_q != 7'h7F) begin
            cnt_d = cnt_q + 7'd1;
         end
         if (cnt_q == BIT_OPCODE - 7'd1) begin
            op_d     = {sh_q[6:0], mosi_s};
            stb_op_d = 1'b1;
         end
         if (cnt_q == BIT_ADDR - 7'd1) begin
            addr_d     = {sh_q[22:0], mosi_s};
            stb_addr_d = 1'b1;
         end
         if (cnt_q == BIT_WDATA - 7'd1) begin
            wdata_d     = {sh_q[30:0], mosi_s};
            stb_wdata_d = 1'b1;
         end
      end

      // Falling edge after bit 39 loads the word so bit 40 is on MISO
      // before the host's next rising edge.
      if (cs_active && sck_fall) begin
         if (cnt_q == BIT_DUMMY) begin
            out_d = rd_data;
         end else if (cnt_q > BIT_DUMMY) begin
            out_d = {out_q[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= '0;
         cnt_q       <= '0;
         sh_q        <= '0;
         op_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         out_q       <= '0;
         stb_op_q    <= 1'b0;
         stb_addr_q  <= 1'b0;
         stb_wdata_q <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         out_q       <= out_d;
         stb_op_q    <= stb_op_d;
         stb_addr_q  <= stb_addr_d;
         stb_wdata_q <= stb_wdata_d;
      end
   end

   assign stb_opcode  = stb_op_q;
   assign stb_addr    = stb_addr_q;
   assign stb_wdata   = stb_wdata_q;
   assign opcode      = op_q;
   assign addr24      = addr_q;
   assign wdata       = wdata_q;
   assign spi_miso_oe = cs_active & (op_q == OP_READ) & (cnt_q >= BIT_DUMMY);
   assign spi_miso    = spi_miso_oe & out_q[31];

endmodule

// File: rtl/silife_spi_wb_bridge.sv
// ----------------------------------------------------------------------------
// silife_spi_wb_bridge
// Lets an external SPI host issue single Wishbone classic reads/writes into
// the silife register map. Frame: opcode, addr24, then 32-bit write data
// (write) or a dummy byte followed by 32-bit read data on MISO (read).
//
// Ports:
//   clk, reset                 system clock, synchronous active-low reset
//   spi_sck/cs/mosi            SPI host pins (asynchronous)
//   spi_miso, spi_miso_oe      read data out, MSB first, and its enable
//   o_wb_cyc/stb/we/sel/addr/data  Wishbone initiator outputs
//   i_wb_ack, i_wb_data        Wishbone responder inputs
//   o_busy                     transaction in flight
//   o_err                      sticky: timeout, overrun or bad opcode
//
// state   | meaning
// --------+---------------------------------------------------------------
// WB_IDLE | no transaction; a request starts one on the next edge
// WB_REQ  | cyc/stb asserted, waiting for ack or timeout
// WB_DONE | one-cycle recovery after ack/timeout
// ----------------------------------------------------------------------------
module silife_spi_wb_bridge
   import silife_pkg::*;
#(
   parameter logic [7:0] ADDR_HI    = 8'h30,
   parameter int         WB_TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_sck,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_data,
   output logic        o_busy,
   output logic        o_err
);

   localparam int TMO_W = (WB_TIMEOUT > 2) ? $clog2(WB_TIMEOUT) : 1;
   // Down-counter loaded on entry; reaching zero marks cycle WB_TIMEOUT.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(WB_TIMEOUT - 1);

   logic        stb_opcode, stb_addr, stb_wdata;
   logic [7:0]  opcode;
   logic [23:0] addr24;
   logic [31:0] wdata;

   wb_state_t        state_q, state_d;
   logic             cyc_q, cyc_d;
   logic             stb_q, stb_d;
   logic             we_q, we_d;
   logic [31:0]      adr_q, adr_d;
   logic [31:0]      dat_q, dat_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;

   logic rd_req, wr_req, req, bad_op, clr_err, err_set;

   silife_spi_target_shifter u_shifter (
      .clk         (clk),
      .reset       (reset),
      .spi_sck     (spi_sck),
      .spi_cs      (spi_cs),
      .spi_mosi    (spi_mosi),
      .rd_data     (rdata_q),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .stb_opcode  (stb_opcode),
      .stb_addr    (stb_addr),
      .stb_wdata   (stb_wdata),
      .opcode      (opcode),
      .addr24      (addr24),
      .wdata       (wdata)
   );

   always_comb begin
      rd_req  = stb_addr & (opcode == OP_READ);
      wr_req  = stb_wdata & (opcode == OP_WRITE);
      req     = rd_req | wr_req;
      bad_op  = stb_opcode & ~op_is_known(opcode);
      clr_err = stb_opcode & (opcode == OP_CLR_ERR);
      err_set = bad_op;

      state_d = state_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rdata_d = rdata_q;
      tmo_d   = tmo_q;

      case (state_q)
         WB_IDLE: begin
            if (req) begin
               state_d = WB_REQ;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = wr_req;
               adr_d   = {ADDR_HI, addr24};
               if (wr_req) begin
                  dat_d = wdata;
               end
               tmo_d = TMO_LOAD;
            end
         end
         WB_REQ: begin
            if (i_wb_ack) begin
               state_d = WB_DONE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               if (!we_q) begin
                  rdata_d = i_wb_data;
               end
            end else if (tmo_q == '0) begin
               state_d = WB_DONE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               err_set = 1'b1;
               if (!we_q) begin
                  rdata_d = 32'hFFFF_FFFF;
               end
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         WB_DONE: begin
            state_d = WB_IDLE;
         end
         default: begin
            state_d = WB_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase

      // Overrun: a new command while the previous one is still running.
      if (req && (state_q != WB_IDLE)) begin
         err_set = 1'b1;
      end

      err_d = err_q;
      if (clr_err) begin
         err_d = 1'b0;
      end
      if (err_set) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= WB_IDLE;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         rdata_q <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdata_q <= rdata_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign o_wb_cyc  = cyc_q;
   assign o_wb_stb  = stb_q;
   assign o_wb_we   = we_q;
   assign o_wb_sel  = 4'hF;
   assign o_wb_addr = adr_q;
   assign o_wb_data = dat_q;
   assign o_busy    = (state_q != WB_IDLE);
   assign o_err     = err_q;

endmodule

// File: tb/tb_silife_spi_wb_bridge.sv
// ----------------------------------------------------------------------------
// tb_silife_spi_wb_bridge
// Directed frames against the bridge. u_dut uses the default 32-clk timeout;
// u_long shares the SPI pins but has a timeout longer than a whole frame so
// a second command can arrive while the first is still held (overrun).
// ----------------------------------------------------------------------------
module tb_silife_spi_wb_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        spi_sck, spi_cs, spi_mosi;
   logic        spi_miso, spi_miso_oe;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [3:0]  o_wb_sel;
   logic [31:0] o_wb_addr, o_wb_data;
   logic        i_wb_ack = 1'b0;
   logic [31:0] i_wb_data;
   logic        o_busy, o_err;

   logic        l_miso, l_oe, l_cyc, l_stb, l_we, l_busy, l_err;
   logic [3:0]  l_sel;
   logic [31:0] l_addr, l_data;
   logic        ack2 = 1'b0;
   logic [31:0] l_rdata = 32'h0;

   silife_spi_wb_bridge #(.ADDR_HI(8'h30), .WB_TIMEOUT(32)) u_dut (
      .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs(spi_cs),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_sel(o_wb_sel), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data), .o_busy(o_busy), .o_err(o_err)
   );

   silife_spi_wb_bridge #(.ADDR_HI(8'h30), .WB_TIMEOUT(2000)) u_long (
      .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs(spi_cs),
      .spi_mosi(spi_mosi), .spi_miso(l_miso), .spi_miso_oe(l_oe),
      .o_wb_cyc(l_cyc), .o_wb_stb(l_stb), .o_wb_we(l_we),
      .o_wb_sel(l_sel), .o_wb_addr(l_addr), .o_wb_data(l_data),
      .i_wb_ack(ack2), .i_wb_data(l_rdata), .o_busy(l_busy), .o_err(l_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Main responder and cycle monitor.
   logic        ack_en     = 1'b1;
   int          ack_delay  = 3;
   int          ack_wait   = 0;
   int          cyc_starts = 0;
   int          cyc_len    = 0;
   logic        cyc_prev   = 1'b0;
   logic [31:0] cap_addr   = '0;
   logic [31:0] cap_data   = '0;
   logic        cap_we     = 1'b0;

   always @(negedge clk) begin
      if (o_wb_cyc && !cyc_prev) begin
         cyc_starts++;
         cyc_len  = 0;
         cap_addr = o_wb_addr;
         cap_data = o_wb_data;
         cap_we   = o_wb_we;
      end
      if (o_wb_cyc) cyc_len++;
      cyc_prev = o_wb_cyc;
      if (o_wb_cyc && o_wb_stb && ack_en && !i_wb_ack) begin
         if (ack_wait >= ack_delay) i_wb_ack = 1'b1;
         else ack_wait++;
      end else begin
         i_wb_ack = 1'b0;
         ack_wait = 0;
      end
   end

   // Long-timeout instance: acks the cycle after cyc unless held.
   logic hold2      = 1'b0;
   int   l_starts   = 0;
   logic l_cyc_prev = 1'b0;

   always @(negedge clk) begin
      if (l_cyc && !l_cyc_prev) l_starts++;
      l_cyc_prev = l_cyc;
      ack2 = l_cyc && !ack2 && !hold2;
   end

   // SPI host, mode 0, SCK = clk/8. Frame bit i is frame[71-i]; MISO and
   // its enable are sampled just before each rising edge.
   logic [71:0] miso_bits, oe_bits;

   task automatic send_frame(input logic [71:0] frame, input int nbits);
      miso_bits = '0;
      oe_bits   = '0;
      spi_cs    = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = frame[71-i];
         repeat (4) @(negedge clk);
         miso_bits[i] = spi_miso;
         oe_bits[i]   = spi_miso_oe;
         spi_sck = 1'b1;
         repeat (4) @(negedge clk);
         spi_sck = 1'b0;
      end
      repeat (4) @(negedge clk);
      spi_cs   = 1'b1;
      spi_mosi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   function automatic logic [31:0] miso_word();
      logic [31:0] w;
      w = '0;
      for (int i = 40; i < 72; i++) w = {w[30:0], miso_bits[i]};
      return w;
   endfunction

   logic [71:0] exp_oe;
   int          l_base;
   int          k;

   initial begin
      reset     = 1'b0;
      spi_cs    = 1'b1;
      spi_sck   = 1'b0;
      spi_mosi  = 1'b0;
      i_wb_data = 32'h0;
      for (int i = 0; i < 72; i++) exp_oe[i] = (i >= 40);

      repeat (3) @(negedge clk);
      chk("rst_cyc",  {127'h0, o_wb_cyc}, 128'h0);
      chk("rst_stb",  {127'h0, o_wb_stb}, 128'h0);
      chk("rst_we",   {127'h0, o_wb_we}, 128'h0);
      chk("rst_sel",  {124'h0, o_wb_sel}, 128'hF);
      chk("rst_addr", {96'h0, o_wb_addr}, 128'h0);
      chk("rst_data", {96'h0, o_wb_data}, 128'h0);
      chk("rst_miso", {126'h0, spi_miso, spi_miso_oe}, 128'h0);
      chk("rst_busy_err", {126'h0, o_busy, o_err}, 128'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Write, ack 3 clk after cyc is seen.
      send_frame({8'h02, 24'h000010, 32'h0000_0001, 8'h00}, 64);
      chk("wr_starts", 128'(cyc_starts), 128'd1);
      chk("wr_addr",   {96'h0, cap_addr}, 128'h3000_0010);
      chk("wr_data",   {96'h0, cap_data}, 128'h1);
      chk("wr_we",     {127'h0, cap_we}, 128'h1);
      chk("wr_cyc_len", 128'(cyc_len), 128'd4);
      chk("wr_err",    {127'h0, o_err}, 128'h0);

      // Read, ack 1 clk after cyc is seen.
      ack_delay = 1;
      i_wb_data = 32'hA5A5_0F0F;
      send_frame({8'h03, 24'h001004, 40'h0}, 72);
      chk("rd_starts", 128'(cyc_starts), 128'd2);
      chk("rd_addr",   {96'h0, cap_addr}, 128'h3000_1004);
      chk("rd_we",     {127'h0, cap_we}, 128'h0);
      chk("rd_miso",   {96'h0, miso_word()}, 128'hA5A5_0F0F);
      chk("rd_oe",     {56'h0, oe_bits}, {56'h0, exp_oe});
      chk("rd_oe_after", {127'h0, spi_miso_oe}, 128'h0);
      chk("rd_err",    {127'h0, o_err}, 128'h0);

      // Read with no ack: timeout.
      ack_en    = 1'b0;
      i_wb_data = 32'h1234_5678;
      send_frame({8'h03, 24'h000100, 40'h0}, 72);
      chk("tmo_starts", 128'(cyc_starts), 128'd3);
      chk("tmo_cyc_len", 128'(cyc_len), 128'd32);
      chk("tmo_miso",  {96'h0, miso_word()}, 128'hFFFF_FFFF);
      chk("tmo_err",   {127'h0, o_err}, 128'h1);
      chk("tmo_busy",  {127'h0, o_busy}, 128'h0);
      send_frame({8'h05, 64'h0}, 8);
      chk("clr_err",   {127'h0, o_err}, 128'h0);
      ack_en    = 1'b1;
      ack_delay = 3;

      // Unknown opcode.
      send_frame({8'h7E, 24'h000010, 32'h0000_0001, 8'h00}, 64);
      chk("bad_starts", 128'(cyc_starts), 128'd3);
      chk("bad_err",   {127'h0, o_err}, 128'h1);
      send_frame({8'h05, 64'h0}, 8);
      chk("bad_clr",   {127'h0, o_err}, 128'h0);

      // Write aborted after 50 bits, then a full write.
      send_frame({8'h02, 24'h000010, 32'h0000_0001, 8'h00}, 50);
      chk("abort_starts", 128'(cyc_starts), 128'd3);
      chk("abort_err", {127'h0, o_err}, 128'h0);
      send_frame({8'h02, 24'h000020, 32'hDEAD_BEEF, 8'h00}, 64);
      chk("post_abort_starts", 128'(cyc_starts), 128'd4);
      chk("post_abort_addr", {96'h0, cap_addr}, 128'h3000_0020);
      chk("post_abort_data", {96'h0, cap_data}, 128'hDEAD_BEEF);

      // Overrun on the long-timeout instance.
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      l_base = l_starts;
      hold2  = 1'b1;
      send_frame({8'h02, 24'h000030, 32'h1111_1111, 8'h00}, 64);
      chk("ovr_first_err", {127'h0, l_err}, 128'h0);
      send_frame({8'h02, 24'h000034, 32'h2222_2222, 8'h00}, 64);
      chk("ovr_err",   {127'h0, l_err}, 128'h1);
      chk("ovr_busy",  {127'h0, l_busy}, 128'h1);
      chk("ovr_addr",  {96'h0, l_addr}, 128'h3000_0030);
      chk("ovr_data",  {96'h0, l_data}, 128'h1111_1111);
      hold2 = 1'b0;
      repeat (5) @(negedge clk);
      chk("ovr_done_cyc", {127'h0, l_cyc}, 128'h0);
      chk("ovr_starts", 128'(l_starts - l_base), 128'd1);
      chk("ovr_main_err", {127'h0, o_err}, 128'h0);

      // Reset while a write is held without ack.
      ack_en = 1'b0;
      send_frame({8'h02, 24'h000040, 32'h0BAD_F00D, 8'h00}, 64);
      k = 0;
      while (!o_wb_cyc && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rst_mid_cyc_seen", {127'h0, o_wb_cyc}, 128'h1);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_cyc",  {126'h0, o_wb_cyc, o_wb_stb}, 128'h0);
      chk("rst_mid_we",   {127'h0, o_wb_we}, 128'h0);
      chk("rst_mid_sel",  {124'h0, o_wb_sel}, 128'hF);
      chk("rst_mid_addr", {96'h0, o_wb_addr}, 128'h0);
      chk("rst_mid_data", {96'h0, o_wb_data}, 128'h0);
      chk("rst_mid_flags", {124'h0, o_busy, o_err, spi_miso, spi_miso_oe}, 128'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/silife_spi_wb_bridge.md
# silife_spi_wb_bridge

External-host SPI-target-to-Wishbone-initiator bridge for the silife design. An off-chip controller shifts framed read/write commands over SPI mode 0, and the block issues single Wishbone classic transactions into the silife register map, including the grid window and the MAX7219 control registers. Read data is returned on MISO within the same frame. It lets a host drive the Game-of-Life core without the management SoC.

## Interface
- `ADDR_HI`, 8'h30: upper byte placed on `o_wb_addr[31:24]`.
- `WB_TIMEOUT`, 32: clk cycles to wait for `i_wb_ack` before abort (≥2, ≤48).
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-low.
- `spi_sck` in 1: SPI clock from host, asynchronous.
- `spi_cs` in 1: SPI chip select, active-low, asynchronous.
- `spi_mosi` in 1: host data, asynchronous.
- `spi_miso` out 1: read data, MSB first.
- `spi_miso_oe` out 1: MISO output enable.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone strobes.
- `o_wb_sel` out 4: constant 4'hF.
- `o_wb_addr` out 32: `{ADDR_HI, addr24}`.
- `o_wb_data` out 32: write data.
- `i_wb_ack` in 1: responder acknowledge.
- `i_wb_data` in 32: responder read data.
- `o_busy` out 1: Wishbone transaction in flight.
- `o_err` out 1: sticky error. Set by timeout, overrun, or bad opcode. Cleared by reset or by opcode 0x05.

## Operation
- Inputs pass through 2-flop synchronizers. SCK rising and falling edges are detected from the synchronized samples; a third flop provides the history for edge detection. CS is handled the same way.
- Frame starts on CS falling. Bit counter (7 bit) and shift register clear. MOSI is sampled on SCK rise, MSB first.
- Byte 0 is the opcode:
  - 0x02: write.
  - 0x03: read.
  - 0x05: clear `o_err`, takes effect at bit 8.
  - Any other value sets `o_err`; the rest of the frame is ignored.
- Bytes 1–3 carry `addr24`.
- Write: bytes 4–7 carry data. At bit 64 a write request is raised.
- Read: at bit 32 a read request is raised. Byte 4 is a dummy byte. Bytes 5–8 shift out the captured data.
- Wishbone FSM has states WB_IDLE, WB_REQ, WB_DONE:
  - WB_IDLE → WB_REQ on request. `cyc`, `stb`, `we`, `addr`, `data` are registered and held stable until ack.
  - WB_REQ → WB_DONE on `i_wb_ack`. Read data is captured and `cyc`/`stb` drop on the next edge.
  - WB_REQ → WB_DONE on timeout. Read data becomes 32'hFFFF_FFFF and `o_err` sets.
  - WB_DONE → WB_IDLE after one cycle.
- Overrun: a request arriving while not in WB_IDLE is dropped and sets `o_err`.
- CS rising mid-frame: bit counter resets and any partial write is discarded. An in-flight Wishbone transaction completes normally.
- MISO:
  - `spi_miso_oe` = CS active AND read opcode AND bit count ≥ 40.
  - The shift-out register loads the captured read data on the SCK falling edge that follows bit 39. It shifts on each later SCK fall.
  - `spi_miso` = register MSB.
  - `spi_miso` = 0 when `spi_miso_oe` is low.
- Bits beyond the frame length are ignored until CS rises.

## Timing
- Reset values: all Wishbone outputs 0, except `o_wb_sel` = 4'hF. `spi_miso` = 0, `spi_miso_oe` = 0, `o_busy` = 0, `o_err` = 0. FSM in WB_IDLE.
- SCK frequency must be ≤ clk/8. The edge-detect latency is 3 clk.
- Request to `o_wb_cyc` high: 1 clk.
- `i_wb_ack` to `o_wb_cyc` low: 1 clk. Single-cycle ack is supported.
- The read transaction must finish within the dummy byte, which lasts at least 64 clk. WB_TIMEOUT is therefore capped at 48.
- `o_busy` = (state ≠ WB_IDLE).
- Timeout counter starts on the first WB_REQ cycle. Abort occurs on cycle `WB_TIMEOUT`.
- Reset asserted mid-transaction: `cyc`/`stb` drop on the same edge and the frame is discarded.

## Structure
- `silife_pkg` holds:
  - Opcodes OP_WRITE = 8'h02, OP_READ = 8'h03, OP_CLR_ERR = 8'h05.
  - Frame bit positions 8, 32, 40, 64.
  - The Wishbone FSM state enum.
- One sub-module, `silife_spi_target_shifter`, contains the synchronizers, edge detect, bit counter, MOSI shift-in, and MISO shift-out. It exports bit-count strobes and the assembled fields.
- The top level holds the Wishbone FSM, timeout counter, and error logic.

## Test plan
- Write frame 0x02, 0x000010, 0x00000001 → one cycle with `o_wb_addr` = 0x30000010, `o_wb_data` = 1, `we` = 1. Ack after 3 clk → `cyc` low 1 clk later, `o_err` = 0.
- Read frame 0x03, 0x001004 with the responder returning 0xA5A5_0F0F → MISO bits 40–71 = 0xA5A50F0F MSB first, and `spi_miso_oe` is high only during those bits.
- Read with no ack → `cyc` held for exactly 32 clk, MISO returns 0xFFFFFFFF, `o_err` = 1. A following 0x05 frame clears `o_err`.
- Opcode 0x7E → no Wishbone cycle, `o_err` = 1.
- Write frame with CS raised after 50 bits → no Wishbone cycle. The next full write frame executes normally.
- A second write frame completing while the first is held without ack → second is dropped, `o_err` = 1, exactly one Wishbone cycle observed. Reset asserted mid-cycle → all outputs return to reset values on the next edge.
